// File: rtl/fft_pkg.sv
// Shared widths and FSM encoding for the FFT bin power block.
package fft_pkg;

    localparam int DW    = 23;
    localparam int PW    = 11;
    localparam int POW_W = 2 * DW;
    localparam int TOT_W = 2 * DW + PW;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_e;

endpackage

// File: rtl/fft_cplx_sq.sv
// Two-stage |x|^2 datapath: S1 registers both squares, S2 registers their sum.
// A sideband word travels with each beat so markers stay aligned with the power.
module fft_cplx_sq #(
    parameter int DW  = 23,
    parameter int SBW = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_re,
    input  logic [DW-1:0]     in_im,
    input  logic [SBW-1:0]    in_sb,
    output logic              out_valid,
    output logic [2*DW-1:0]   out_power,
    output logic [SBW-1:0]    out_sb
);

    logic signed [2*DW-1:0] re_ext;
    logic signed [2*DW-1:0] im_ext;

    logic            s1_valid_q, s1_valid_d;
    logic [2*DW-1:0] sq_re_q, sq_re_d;
    logic [2*DW-1:0] sq_im_q, sq_im_d;
    logic [SBW-1:0]  s1_sb_q, s1_sb_d;
    logic            s2_valid_q, s2_valid_d;
    logic [2*DW-1:0] pow_q, pow_d;
    logic [SBW-1:0]  s2_sb_q, s2_sb_d;

    // Each square of a DW-bit signed value fits in 2*DW-1 bits, so the sum never overflows 2*DW.
    always_comb begin
        re_ext     = {{DW{in_re[DW-1]}}, in_re};
        im_ext     = {{DW{in_im[DW-1]}}, in_im};
        s1_valid_d = s1_valid_q;
        sq_re_d    = sq_re_q;
        sq_im_d    = sq_im_q;
        s1_sb_d    = s1_sb_q;
        s2_valid_d = s2_valid_q;
        pow_d      = pow_q;
        s2_sb_d    = s2_sb_q;
        if (en) begin
            s1_valid_d = in_valid;
            sq_re_d    = re_ext * re_ext;
            sq_im_d    = im_ext * im_ext;
            s1_sb_d    = in_sb;
            s2_valid_d = s1_valid_q;
            pow_d      = sq_re_q + sq_im_q;
            s2_sb_d    = s1_sb_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            sq_re_q    <= '0;
            sq_im_q    <= '0;
            s1_sb_q    <= '0;
            s2_valid_q <= 1'b0;
            pow_q      <= '0;
            s2_sb_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            sq_re_q    <= sq_re_d;
            sq_im_q    <= sq_im_d;
            s1_sb_q    <= s1_sb_d;
            s2_valid_q <= s2_valid_d;
            pow_q      <= pow_d;
            s2_sb_q    <= s2_sb_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign out_power = pow_q;
    assign out_sb    = s2_sb_q;

endmodule

// File: rtl/fft_power_bin.sv
// Per-bin power of a streaming FFT frame with bin numbering, frame sum and protocol checks.
// Handshake: a beat moves when valid && ready; sink_ready = source_ready || !source_valid.
module fft_power_bin #(
    parameter int DW = fft_pkg::DW,
    parameter int PW = fft_pkg::PW
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sink_valid,
    output logic                 sink_ready,
    input  logic [1:0]           sink_error,
    input  logic                 sink_sop,
    input  logic                 sink_eop,
    input  logic [DW-1:0]        sink_real,
    input  logic [DW-1:0]        sink_imag,
    input  logic [PW-1:0]        fftpts_in,
    output logic                 source_valid,
    input  logic                 source_ready,
    output logic [1:0]           source_error,
    output logic                 source_sop,
    output logic                 source_eop,
    output logic [2*DW-1:0]      source_power,
    output logic [PW-1:0]        source_bin,
    output logic [2*DW+PW-1:0]   frame_total,
    output logic                 frame_total_valid,
    output logic                 frame_err,
    output logic                 dbg_state
);
    import fft_pkg::*;

    localparam int SBW  = PW + 4;
    localparam int TOTW = 2 * DW + PW;
    localparam logic [PW-1:0] BIN_MAX = '1;

    state_e          state_q, state_d;
    logic [PW-1:0]   bin_q, bin_d;
    logic [PW-1:0]   pts_q, pts_d;
    logic            err_q, err_d;
    logic [TOTW-1:0] acc_q, acc_d;
    logic [TOTW-1:0] total_q, total_d;
    logic            ftv_q, ftv_d;

    logic            en;
    logic            accept;
    logic            pass;
    logic [PW-1:0]   beat_bin;
    logic [PW-1:0]   pts_eff;
    logic            sq_valid;
    logic [2*DW-1:0] sq_power;
    logic [SBW-1:0]  sq_sb;
    logic [1:0]      o_err;
    logic            o_sop;
    logic            o_eop;
    logic [PW-1:0]   o_bin;
    logic            emit;
    logic [TOTW-1:0] sum_now;

    assign en         = source_ready || !sq_valid;
    assign sink_ready = en;
    assign accept     = sink_valid && en;

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        pts_d    = pts_q;
        err_d    = err_q;
        pass     = 1'b0;
        beat_bin = bin_q;
        pts_eff  = sink_sop ? fftpts_in : pts_q;
        if (accept) begin
            if (state_q == ST_IDLE && !sink_sop) begin
                err_d = 1'b1;
            end else begin
                pass = 1'b1;
                if (sink_sop) begin
                    beat_bin = '0;
                    pts_d    = fftpts_in;
                    if (state_q == ST_FRAME) err_d = 1'b1;
                end
                // Natural wrap of the counter covers the 2^PW-1 -> 0 case.
                bin_d = beat_bin + PW'(1);
                if (sink_eop) begin
                    state_d = ST_IDLE;
                    if (beat_bin != pts_eff - PW'(1)) err_d = 1'b1;
                end else begin
                    state_d = ST_FRAME;
                    if (beat_bin == BIN_MAX) err_d = 1'b1;
                end
            end
        end
    end

    fft_cplx_sq #(
        .DW  (DW),
        .SBW (SBW)
    ) u_sq (
        .clk       (clk),
        .rst_n     (reset_n),
        .en        (en),
        .in_valid  (pass),
        .in_re     (sink_real),
        .in_im     (sink_imag),
        .in_sb     ({sink_error, sink_sop, sink_eop, beat_bin}),
        .out_valid (sq_valid),
        .out_power (sq_power),
        .out_sb    (sq_sb)
    );

    assign {o_err, o_sop, o_eop, o_bin} = sq_sb;

    // The running sum follows emission order, so a restart sop simply reseeds it.
    always_comb begin
        emit    = sq_valid && source_ready;
        sum_now = (o_sop ? '0 : acc_q) + TOTW'(sq_power);
        acc_d   = emit ? sum_now : acc_q;
        total_d = (emit && o_eop) ? sum_now : total_q;
        ftv_d   = emit && o_eop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            pts_q   <= '0;
            err_q   <= 1'b0;
            acc_q   <= '0;
            total_q <= '0;
            ftv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            pts_q   <= pts_d;
            err_q   <= err_d;
            acc_q   <= acc_d;
            total_q <= total_d;
            ftv_q   <= ftv_d;
        end
    end

    assign source_valid      = sq_valid;
    assign source_error      = o_err;
    assign source_sop        = o_sop;
    assign source_eop        = o_eop;
    assign source_power      = sq_power;
    assign source_bin        = o_bin;
    assign frame_total       = total_q;
    assign frame_total_valid = ftv_q;
    assign frame_err         = err_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_fft_power_bin.sv
// Bench for fft_power_bin: directed table frames, multi-cycle corner sequences and random frames.
module tb_fft_power_bin;
    localparam int DW   = 23;
    localparam int PW   = 11;
    localparam int TOTW = 2 * DW + PW;
    localparam int W    = 2 * DW + PW + 4;
    localparam int NB   = 1 << PW;

    typedef struct {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
        logic                 sop;
        logic                 eop;
        logic [2*DW-1:0]      exp_pow;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b1;
    logic                 sink_valid = 1'b0;
    logic                 sink_ready;
    logic [1:0]           sink_error = '0;
    logic                 sink_sop = 1'b0;
    logic                 sink_eop = 1'b0;
    logic [DW-1:0]        sink_real = '0;
    logic [DW-1:0]        sink_imag = '0;
    logic [PW-1:0]        fftpts_in = '0;
    logic                 source_valid;
    logic                 source_ready = 1'b1;
    logic [1:0]           source_error;
    logic                 source_sop;
    logic                 source_eop;
    logic [2*DW-1:0]      source_power;
    logic [PW-1:0]        source_bin;
    logic [TOTW-1:0]      frame_total;
    logic                 frame_total_valid;
    logic                 frame_err;
    logic                 dbg_state;

    fft_power_bin #(.DW(DW), .PW(PW)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .sink_valid        (sink_valid),
        .sink_ready        (sink_ready),
        .sink_error        (sink_error),
        .sink_sop          (sink_sop),
        .sink_eop          (sink_eop),
        .sink_real         (sink_real),
        .sink_imag         (sink_imag),
        .fftpts_in         (fftpts_in),
        .source_valid      (source_valid),
        .source_ready      (source_ready),
        .source_error      (source_error),
        .source_sop        (source_sop),
        .source_eop        (source_eop),
        .source_power      (source_power),
        .source_bin        (source_bin),
        .frame_total       (frame_total),
        .frame_total_valid (frame_total_valid),
        .frame_err         (frame_err),
        .dbg_state         (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [W-1:0]    exp_q[$];
    logic [TOTW-1:0] exp_tot_q[$];
    logic [2*DW-1:0] pow_log[$];
    logic [PW-1:0]   bin_log[$];
    logic [TOTW-1:0] last_total = '0;
    int ftv_cnt = 0;
    int rdy_mode = 0;
    int cyc = 0;
    bit started = 0;
    logic [3:0] rdy_pat = 4'b1001;
    vec_t tbl[4];

    // Reference model state
    bit      m_in_frame;
    int      m_bin;
    int      m_pts;
    bit      m_err;
    longint  m_sum;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rdy_mode == 0) source_ready = 1'b1;
        else if (rdy_mode == 1) source_ready = rdy_pat[cyc % 4];
        else source_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard
    always @(negedge clk) begin
        if (started && reset_n) begin
            check("sink_ready_en", 64'(sink_ready), 64'(source_ready || !source_valid));
            if (source_valid && source_ready) begin
                pow_log.push_back(source_power);
                bin_log.push_back(source_bin);
                if (exp_q.size() == 0) check("beat_expected", 64'(exp_q.size()), 64'd1);
                else check("beat", 64'({source_error, source_sop, source_eop, source_bin, source_power}),
                           64'(exp_q.pop_front()));
            end
            if (frame_total_valid) begin
                last_total = frame_total;
                ftv_cnt++;
                if (exp_tot_q.size() == 0) check("total_expected", 64'(exp_tot_q.size()), 64'd1);
                else check("frame_total", 64'(frame_total), 64'(exp_tot_q.pop_front()));
            end
        end
    end

    task automatic model_clear();
        m_in_frame = 0;
        m_bin = 0;
        m_pts = 0;
        m_err = 0;
        m_sum = 0;
        exp_q.delete();
        exp_tot_q.delete();
    endtask

    task automatic model_beat(input logic [1:0] e, input logic s, input logic eo,
                              input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                              input logic [PW-1:0] pts);
        longint p;
        logic [PW-1:0] b;
        logic [2*DW-1:0] pw;
        if (!m_in_frame && !s) begin
            m_err = 1;
            return;
        end
        if (s) begin
            if (m_in_frame) m_err = 1;
            m_bin = 0;
            m_pts = int'(pts);
            m_sum = 0;
        end
        p = longint'(re) * longint'(re) + longint'(im) * longint'(im);
        b = m_bin[PW-1:0];
        pw = p[2*DW-1:0];
        exp_q.push_back({e, s, eo, b, pw});
        m_sum += p;
        if (eo) begin
            if (m_bin != (m_pts + NB - 1) % NB) m_err = 1;
            exp_tot_q.push_back(m_sum[TOTW-1:0]);
            m_in_frame = 0;
        end else begin
            if (m_bin == NB - 1) m_err = 1;
            m_bin = (m_bin + 1) % NB;
            m_in_frame = 1;
        end
    endtask

    // Driver: called off-edge; returns at posedge+1 after acceptance.
    task automatic send_beat(input logic [1:0] e, input logic s, input logic eo,
                             input logic signed [DW-1:0] re, input logic signed [DW-1:0] im,
                             input logic [PW-1:0] pts);
        int n = 0;
        sink_error = e;
        sink_sop = s;
        sink_eop = eo;
        sink_real = re;
        sink_imag = im;
        fftpts_in = pts;
        sink_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (sink_ready) break;
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'd0, 64'd1);
                sink_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        model_beat(e, s, eo, re, im, pts);
        #1;
        sink_valid = 1'b0;
    endtask

    task automatic rand_beat(input logic s, input logic eo, input logic [PW-1:0] pts);
        logic [31:0] a;
        logic [31:0] c;
        a = $urandom;
        c = $urandom;
        send_beat(2'($urandom_range(0, 3)), s, eo, a[DW-1:0], c[DW-1:0], pts);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        sink_valid = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_source_valid", 64'(source_valid), 64'd0);
        check("rst_source_power", 64'(source_power), 64'd0);
        check("rst_frame_total", 64'(frame_total), 64'd0);
        check("rst_total_valid", 64'(frame_total_valid), 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        check("rst_sink_ready", 64'(sink_ready), 64'd1);
        check("rst_state", 64'(dbg_state), 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        started = 1;
        pow_log.delete();
        bin_log.delete();
        ftv_cnt = 0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() > 0 || exp_tot_q.size() > 0) && n < 400) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("drain_beats", 64'(exp_q.size()), 64'd0);
        check("drain_totals", 64'(exp_tot_q.size()), 64'd0);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < 4; i++) send_beat(2'd0, tbl[i].sop, tbl[i].eop, tbl[i].re, tbl[i].im, 11'd4);
        wait_drain();
        check({tag, "_count"}, 64'(pow_log.size()), 64'd4);
        for (int i = 0; i < 4 && i < pow_log.size(); i++) begin
            check({tag, "_power"}, 64'(pow_log[i]), 64'(tbl[i].exp_pow));
            check({tag, "_bin"}, 64'(bin_log[i]), 64'(i));
        end
        check({tag, "_total"}, 64'(last_total), (64'd1 << 45) + 64'd30);
        check({tag, "_ftv_cnt"}, 64'(ftv_cnt), 64'd1);
        check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    endtask

    initial begin
        longint new_sum;
        int len;
        int pts;
        tbl[0] = '{re: 23'sd1,        im: 23'sd0,        sop: 1'b1, eop: 1'b0, exp_pow: 46'd1};
        tbl[1] = '{re: 23'sd0,        im: 23'sd2,        sop: 1'b0, eop: 1'b0, exp_pow: 46'd4};
        tbl[2] = '{re: -23'sd3,       im: 23'sd4,        sop: 1'b0, eop: 1'b0, exp_pow: 46'd25};
        tbl[3] = '{re: -23'sd4194304, im: -23'sd4194304, sop: 1'b0, eop: 1'b1, exp_pow: 46'h2000_0000_0000};

        @(posedge clk);
        #1;
        do_reset();

        // Table frame, ready held high, then with ready toggling 1,0,0,1
        rdy_mode = 0;
        run_table("tbl_rdy1");
        pow_log.delete();
        bin_log.delete();
        ftv_cnt = 0;
        rdy_mode = 1;
        run_table("tbl_toggle");
        check("tbl_state", 64'(dbg_state), 64'd0);

        // Beat without sop after reset is dropped
        rdy_mode = 0;
        do_reset();
        send_beat(2'd0, 1'b0, 1'b0, 23'sd5, 23'sd5, 11'd4);
        wait_drain();
        check("nosop_outputs", 64'(pow_log.size()), 64'd0);
        check("nosop_err", 64'(frame_err), 64'd1);

        // Short frame: fftpts=8, eop on 6th beat
        do_reset();
        for (int i = 0; i < 6; i++) rand_beat(i == 0, i == 5, 11'd8);
        wait_drain();
        check("short_count", 64'(pow_log.size()), 64'd6);
        check("short_err", 64'(frame_err), 64'd1);
        check("short_ftv_cnt", 64'(ftv_cnt), 64'd1);

        // sop arriving at bin 3 restarts the frame
        do_reset();
        for (int i = 0; i < 3; i++) rand_beat(i == 0, 1'b0, 11'd8);
        new_sum = 0;
        for (int i = 0; i < 4; i++) begin
            send_beat(2'd0, i == 0, i == 3, 23'(i + 2), -23'sd3, 11'd4);
            new_sum += longint'((i + 2) * (i + 2) + 9);
        end
        wait_drain();
        check("restart_bin", 64'(bin_log.size() > 3 ? bin_log[3] : 11'h7ff), 64'd0);
        check("restart_err", 64'(frame_err), 64'd1);
        check("restart_total", 64'(last_total), 64'(new_sum));
        check("restart_ftv_cnt", 64'(ftv_cnt), 64'd1);

        // Reset mid-frame with beats in flight, then a clean frame
        do_reset();
        for (int i = 0; i < 3; i++) rand_beat(i == 0, 1'b0, 11'd6);
        do_reset();
        run_table("post_reset");

        // Bin counter wrap without eop
        do_reset();
        for (int i = 0; i < NB - 1; i++) send_beat(2'd0, i == 0, 1'b0, 23'(i % 7), 23'sd1, 11'd0);
        check("wrap_err_before", 64'(frame_err), 64'd0);
        send_beat(2'd0, 1'b0, 1'b0, 23'sd1, 23'sd1, 11'd0);
        check("wrap_err_after", 64'(frame_err), 64'd1);
        send_beat(2'd0, 1'b0, 1'b0, 23'sd2, 23'sd1, 11'd0);
        send_beat(2'd0, 1'b0, 1'b1, 23'sd3, 23'sd1, 11'd0);
        wait_drain();
        check("wrap_bin0", 64'(bin_log.size() > NB ? bin_log[NB] : 11'h7ff), 64'd0);
        check("wrap_state", 64'(dbg_state), 64'd1 - 64'd1);

        // Randomized frames with random backpressure and protocol errors
        do_reset();
        rdy_mode = 2;
        for (int f = 0; f < 40; f++) begin
            pts = $urandom_range(1, 10);
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 10) : pts;
            if ($urandom_range(0, 7) == 0) rand_beat(1'b0, 1'b0, 11'd4);
            for (int i = 0; i < len; i++) begin
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
                rand_beat(i == 0, i == len - 1, 11'(pts));
            end
        end
        wait_drain();
        check("rand_frame_err", 64'(frame_err), 64'(m_err));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
